// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one 16-bit SRAM between fetch and data ports, 32-bit words as two halfword cycles.
// Define SRAM_ARB_ROUND_ROBIN_EN for alternating priority; otherwise the data port has fixed priority.
module sram_arbiter #(
    parameter int ACCESS_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_mc_en,
    input  logic [17:0] if_mc_addr,
    output logic [31:0] mc_if_data,
    output logic        mc_if_ack,
    input  logic        mem_mc_en,
    input  logic        mem_mc_rw,
    input  logic [17:0] mem_mc_addr,
    input  logic [31:0] mem_mc_wdata,
    output logic [31:0] mc_mem_rdata,
    output logic        mc_mem_ack,
    output logic [17:0] mc_ram_addr,
    output logic        mc_ram_we_n,
    output logic [15:0] mc_ram_dq_out,
    output logic        mc_ram_dq_oe,
    input  logic [15:0] mc_ram_dq_in
);
    localparam int CW = $clog2(ACCESS_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;

    state_t        state, next_state;
    logic [CW-1:0] cnt, next_cnt;
    logic [15:0]   word_q, next_word;
    logic [31:0]   wdata_q, next_wdata;
    logic [15:0]   lo_q;
    logic          own_mem;
    logic          grant_mem, grant_if;
    logic          last, wr_next, hi_next, acc_next;
    logic          unused_addr_lsbs;

    assign unused_addr_lsbs = ^{if_mc_addr[1:0], mem_mc_addr[1:0]};

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic ptr_mem;

    always_comb begin
        grant_mem = 1'b0;
        grant_if  = 1'b0;
        if (mem_mc_en && (ptr_mem || !if_mc_en))
            grant_mem = 1'b1;
        else if (if_mc_en)
            grant_if = 1'b1;
    end
`else
    always_comb begin
        grant_mem = 1'b0;
        grant_if  = 1'b0;
        if (mem_mc_en)
            grant_mem = 1'b1;
        else if (if_mc_en)
            grant_if = 1'b1;
    end
`endif

    assign last = (cnt == LAST);

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        next_word  = word_q;
        next_wdata = wdata_q;
        case (state)
            IDLE: begin
                next_cnt = '0;
                if (grant_mem) begin
                    next_state = mem_mc_rw ? WR_LO : RD_LO;
                    next_word  = mem_mc_addr[17:2];
                    next_wdata = mem_mc_wdata;
                end else if (grant_if) begin
                    next_state = RD_LO;
                    next_word  = if_mc_addr[17:2];
                end
            end
            RD_LO, RD_HI, WR_LO, WR_HI: begin
                next_cnt = cnt + 1'b1;
                if (last) begin
                    next_cnt = '0;
                    if (state == RD_LO)
                        next_state = RD_HI;
                    else if (state == WR_LO)
                        next_state = WR_HI;
                    else
                        next_state = DONE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign wr_next  = (next_state == WR_LO) || (next_state == WR_HI);
    assign hi_next  = (next_state == RD_HI) || (next_state == WR_HI);
    assign acc_next = wr_next || (next_state == RD_LO) || (next_state == RD_HI);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            word_q        <= '0;
            wdata_q       <= '0;
            lo_q          <= '0;
            own_mem       <= 1'b0;
            mc_ram_addr   <= '0;
            mc_ram_we_n   <= 1'b1;
            mc_ram_dq_oe  <= 1'b0;
            mc_ram_dq_out <= '0;
            mc_if_ack     <= 1'b0;
            mc_mem_ack    <= 1'b0;
            mc_if_data    <= '0;
            mc_mem_rdata  <= '0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            ptr_mem       <= 1'b1;
`endif
        end else begin
            state   <= next_state;
            cnt     <= next_cnt;
            word_q  <= next_word;
            wdata_q <= next_wdata;
            if (state == IDLE)
                own_mem <= grant_mem;
            if (acc_next)
                mc_ram_addr <= {1'b0, next_word, hi_next};
            // last cycle of each write half is a hold cycle with we_n released
            mc_ram_we_n   <= !(wr_next && (next_cnt != LAST));
            mc_ram_dq_oe  <= wr_next;
            mc_ram_dq_out <= !wr_next ? 16'h0 :
                             hi_next ? next_wdata[31:16] : next_wdata[15:0];
            mc_if_ack  <= (next_state == DONE) && !own_mem;
            mc_mem_ack <= (next_state == DONE) && own_mem;
            if (last && state == RD_LO)
                lo_q <= mc_ram_dq_in;
            if (last && state == RD_HI) begin
                if (own_mem)
                    mc_mem_rdata <= {mc_ram_dq_in, lo_q};
                else
                    mc_if_data <= {mc_ram_dq_in, lo_q};
            end
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            if (state == IDLE && (grant_mem || grant_if))
                ptr_mem <= !grant_mem;
`endif
        end
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: vector table, hand sequences and randomized run against a word-level model.
module tb_sram_arbiter;
    localparam int AC  = 2;
    localparam int LAT = 2 * AC + 1;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        if_mc_en = 1'b0;
    logic [17:0] if_mc_addr = '0;
    logic [31:0] mc_if_data;
    logic        mc_if_ack;
    logic        mem_mc_en = 1'b0;
    logic        mem_mc_rw = 1'b0;
    logic [17:0] mem_mc_addr = '0;
    logic [31:0] mem_mc_wdata = '0;
    logic [31:0] mc_mem_rdata;
    logic        mc_mem_ack;
    logic [17:0] mc_ram_addr;
    logic        mc_ram_we_n;
    logic [15:0] mc_ram_dq_out;
    logic        mc_ram_dq_oe;
    logic [15:0] mc_ram_dq_in = '0;

    sram_arbiter #(.ACCESS_CYCLES(AC)) dut (
        .clock(clock), .reset(reset),
        .if_mc_en(if_mc_en), .if_mc_addr(if_mc_addr),
        .mc_if_data(mc_if_data), .mc_if_ack(mc_if_ack),
        .mem_mc_en(mem_mc_en), .mem_mc_rw(mem_mc_rw),
        .mem_mc_addr(mem_mc_addr), .mem_mc_wdata(mem_mc_wdata),
        .mc_mem_rdata(mc_mem_rdata), .mc_mem_ack(mc_mem_ack),
        .mc_ram_addr(mc_ram_addr), .mc_ram_we_n(mc_ram_we_n),
        .mc_ram_dq_out(mc_ram_dq_out), .mc_ram_dq_oe(mc_ram_dq_oe),
        .mc_ram_dq_in(mc_ram_dq_in)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;

    function automatic logic [15:0] pat(int a);
        if (a == 8) return 16'h5678;
        if (a == 9) return 16'h1234;
        return 16'(a * 40503) ^ 16'h5A5A;
    endfunction

    // pin-level SRAM: written while we_n is low, read data presented each cycle
    logic [15:0] sram [int];
    always @(negedge clock) begin
        if (!mc_ram_we_n)
            sram[int'(mc_ram_addr)] = mc_ram_dq_out;
        if (sram.exists(int'(mc_ram_addr)))
            mc_ram_dq_in = sram[int'(mc_ram_addr)];
        else
            mc_ram_dq_in = pat(int'(mc_ram_addr));
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        is_mem;
        logic        rw;
        logic [17:0] addr;
        logic [31:0] wdata;
        logic [17:0] exp_ram;
        logic [31:0] exp_if;
        logic [31:0] exp_mem;
    } vec_t;

    vec_t vecs [7];

    task automatic run_vec(input int idx, input vec_t v);
        int lat, wlo, oen, other;
        logic [17:0] a_lo, a_hi;
        logic [15:0] wd0, wd1;
        logic seen;
        lat = 0; wlo = 0; oen = 0; other = 0; seen = 1'b0;
        a_lo = '0; a_hi = '0; wd0 = '0; wd1 = '0;
        @(negedge clock);
        if (v.is_mem) begin
            mem_mc_en = 1'b1; mem_mc_rw = v.rw;
            mem_mc_addr = v.addr; mem_mc_wdata = v.wdata;
        end else begin
            if_mc_en = 1'b1; if_mc_addr = v.addr;
        end
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(negedge clock);
            if (c == 1) a_lo = mc_ram_addr;
            if (c == AC + 1) a_hi = mc_ram_addr;
            if (!mc_ram_we_n) begin
                if (wlo == 0) wd0 = mc_ram_dq_out;
                else wd1 = mc_ram_dq_out;
                wlo++;
            end
            if (mc_ram_dq_oe) oen++;
            if (v.is_mem ? mc_if_ack : mc_mem_ack) other++;
            if (v.is_mem ? mc_mem_ack : mc_if_ack) begin
                seen = 1'b1;
                lat = c;
                chk($sformatf("v%0d_if_data", idx), mc_if_data, v.exp_if);
                chk($sformatf("v%0d_mem_rdata", idx), mc_mem_rdata, v.exp_mem);
            end
        end
        if_mc_en = 1'b0;
        mem_mc_en = 1'b0;
        chk($sformatf("v%0d_latency", idx), lat, LAT);
        chk($sformatf("v%0d_addr_lo", idx), a_lo, v.exp_ram);
        chk($sformatf("v%0d_addr_hi", idx), a_hi, v.exp_ram | 18'h1);
        chk($sformatf("v%0d_other_ack", idx), other, 0);
        if (v.is_mem && v.rw) begin
            chk($sformatf("v%0d_we_cycles", idx), wlo, 2 * (AC - 1));
            chk($sformatf("v%0d_oe_cycles", idx), oen, 2 * AC);
            chk($sformatf("v%0d_wd_lo", idx), wd0, v.wdata[15:0]);
            chk($sformatf("v%0d_wd_hi", idx), wd1, v.wdata[31:16]);
        end else begin
            chk($sformatf("v%0d_we_cycles", idx), wlo, 0);
            chk($sformatf("v%0d_oe_cycles", idx), oen, 0);
        end
    endtask

    logic [31:0] ref_mem [0:63];
    int          m_cnt;
    logic        m_mem, m_rw, m_ptr_mem, win_mem, win_if, e_ia, e_ma;
    logic [5:0]  m_word;
    logic [31:0] m_wdata, m_if_data, m_mem_rd;
    int          n, a1, a2, cyc;
    logic        order [3];
    int          when [3];
    logic        exp_order [3];

    initial begin
        for (int w = 0; w < 64; w++)
            ref_mem[w] = {pat(2 * w + 1), pat(2 * w)};
        vecs[0] = '{1'b0, 1'b0, 18'h00010, 32'h0,        18'h00008, 32'h12345678, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 18'h00020, 32'hDEADBEEF, 18'h00010, 32'h12345678, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 18'h00020, 32'h0,        18'h00010, 32'h12345678, 32'hDEADBEEF};
        vecs[3] = '{1'b0, 1'b0, 18'h00013, 32'h0,        18'h00008, 32'h12345678, 32'hDEADBEEF};
        vecs[4] = '{1'b1, 1'b0, 18'h00023, 32'h0,        18'h00010, 32'h12345678, 32'hDEADBEEF};
        vecs[5] = '{1'b0, 1'b0, 18'h00020, 32'h0,        18'h00010, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[6] = '{1'b1, 1'b0, 18'h00010, 32'h0,        18'h00008, 32'hDEADBEEF, 32'h12345678};

        repeat (3) @(negedge clock);
        chk("rst_if_ack", mc_if_ack, 0);
        chk("rst_mem_ack", mc_mem_ack, 0);
        chk("rst_we_n", mc_ram_we_n, 1);
        chk("rst_oe", mc_ram_dq_oe, 0);
        chk("rst_addr", mc_ram_addr, 0);
        chk("rst_dq_out", mc_ram_dq_out, 0);
        chk("rst_if_data", mc_if_data, 0);
        chk("rst_mem_rdata", mc_mem_rdata, 0);
        reset = 1'b1;

        for (int i = 0; i < 7; i++)
            run_vec(i, vecs[i]);
        ref_mem[8] = 32'hDEADBEEF;

        // enable held past the ack starts an identical second transaction
        @(negedge clock);
        mem_mc_en = 1'b1; mem_mc_rw = 1'b0; mem_mc_addr = 18'h00020;
        n = 0; a1 = 0; a2 = 0;
        for (int c = 1; c <= 16 && n < 2; c++) begin
            @(negedge clock);
            if (mc_mem_ack) begin
                n++;
                if (n == 1) a1 = c;
                else begin
                    a2 = c;
                    mem_mc_en = 1'b0;
                end
                chk("hold_rdata", mc_mem_rdata, 32'hDEADBEEF);
            end
        end
        mem_mc_en = 1'b0;
        chk("hold_ack1", a1, LAT);
        chk("hold_ack2", a2, 2 * LAT + 1);

        // both ports requesting continuously
        @(negedge clock); reset = 1'b0;
        @(negedge clock); reset = 1'b1;
        @(negedge clock);
        if_mc_en = 1'b1; if_mc_addr = 18'h00010;
        mem_mc_en = 1'b1; mem_mc_rw = 1'b0; mem_mc_addr = 18'h00020;
        n = 0;
        for (int c = 1; c <= 30 && n < 3; c++) begin
            @(negedge clock);
            if (mc_if_ack || mc_mem_ack) begin
                order[n] = mc_mem_ack;
                when[n] = c;
                n++;
            end
        end
        if_mc_en = 1'b0;
        mem_mc_en = 1'b0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        exp_order[0] = 1'b1; exp_order[1] = 1'b0; exp_order[2] = 1'b1;
`else
        exp_order[0] = 1'b1; exp_order[1] = 1'b1; exp_order[2] = 1'b1;
`endif
        chk("arb_grants", n, 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("arb_port%0d", i), order[i], exp_order[i]);
            chk($sformatf("arb_cycle%0d", i), when[i], LAT + i * (LAT + 1));
        end

        // reset in the middle of WR_LO
        @(negedge clock);
        mem_mc_en = 1'b1; mem_mc_rw = 1'b1;
        mem_mc_addr = 18'h00190; mem_mc_wdata = 32'hCAFEF00D;
        @(negedge clock);
        chk("abort_we_low", mc_ram_we_n, 0);
        reset = 1'b0;
        mem_mc_en = 1'b0;
        #1;
        chk("abort_we_n", mc_ram_we_n, 1);
        chk("abort_oe", mc_ram_dq_oe, 0);
        chk("abort_mem_ack", mc_mem_ack, 0);
        @(negedge clock); reset = 1'b1;
        n = 0;
        repeat (8) begin
            @(negedge clock);
            if (mc_mem_ack || mc_if_ack) n++;
        end
        chk("abort_no_ack", n, 0);

        // randomized traffic against the word-level model
        m_cnt = 0; m_ptr_mem = 1'b1; m_mem = 1'b0; m_rw = 1'b0;
        m_word = '0; m_wdata = '0; m_if_data = '0; m_mem_rd = '0;
        for (cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clock);
            e_ia = (m_cnt == 1) && !m_mem;
            e_ma = (m_cnt == 1) && m_mem;
            if (e_ia) m_if_data = ref_mem[m_word];
            if (e_ma) begin
                if (m_rw) ref_mem[m_word] = m_wdata;
                else m_mem_rd = ref_mem[m_word];
            end
            chk("r_if_ack", mc_if_ack, e_ia);
            chk("r_mem_ack", mc_mem_ack, e_ma);
            chk("r_if_data", mc_if_data, m_if_data);
            chk("r_mem_rdata", mc_mem_rdata, m_mem_rd);
            if (!mc_ram_we_n) chk("r_we_oe", mc_ram_dq_oe, 1);
            if (e_ia) if_mc_en = 1'b0;
            else if (!if_mc_en && $urandom_range(0, 2) == 0) begin
                if_mc_en = 1'b1;
                if_mc_addr = 18'($urandom_range(0, 255));
            end
            if (e_ma) mem_mc_en = 1'b0;
            else if (!mem_mc_en && $urandom_range(0, 2) == 0) begin
                mem_mc_en = 1'b1;
                mem_mc_rw = 1'($urandom_range(0, 1));
                mem_mc_addr = 18'($urandom_range(0, 255));
                mem_mc_wdata = $urandom;
            end
            if (m_cnt == 0) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
                win_mem = mem_mc_en && (m_ptr_mem || !if_mc_en);
`else
                win_mem = mem_mc_en;
`endif
                win_if = !win_mem && if_mc_en;
                if (win_mem || win_if) begin
                    m_mem = win_mem;
                    m_rw = win_mem && mem_mc_rw;
                    m_word = win_mem ? mem_mc_addr[7:2] : if_mc_addr[7:2];
                    m_wdata = mem_mc_wdata;
                    m_ptr_mem = !win_mem;
                    m_cnt = LAT;
                end
            end else begin
                m_cnt--;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares the single 16-bit external SRAM between the instruction-fetch port and the data-memory port of the memory controller. Each 32-bit word access is split into two sequenced halfword SRAM cycles. Requests are arbitrated, one transaction runs at a time, and completion is signalled with a one-cycle acknowledge. Sits between the fetch/memory stages and the board SRAM pins; the top level owns the tristate on the data bus.

## Interface
- ACCESS_CYCLES, 2: cycles per halfword SRAM access; must be ≥ 2.
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_mc_en  in  1  fetch read request (level).
- if_mc_addr  in  18  fetch byte address; bits [1:0] ignored.
- mc_if_data  out  32  fetch read data.
- mc_if_ack  out  1  fetch transaction complete (1-cycle pulse).
- mem_mc_en  in  1  data-port request (level).
- mem_mc_rw  in  1  1 = write, 0 = read.
- mem_mc_addr  in  18  data byte address; bits [1:0] ignored.
- mem_mc_wdata  in  32  write data.
- mc_mem_rdata  out  32  data-port read data.
- mc_mem_ack  out  1  data transaction complete (1-cycle pulse).
- mc_ram_addr  out  18  SRAM halfword address = {1'b0, A[17:2], half}.
- mc_ram_we_n  out  1  SRAM write enable, active-low.
- mc_ram_dq_out  out  16  data driven to SRAM.
- mc_ram_dq_oe  out  1  1 = top drives SRAM_DQ from mc_ram_dq_out.
- mc_ram_dq_in  in  16  data read from SRAM_DQ.

## Operation
- States: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
- IDLE: samples both enables. A winner latches its address, rw and wdata, then moves to RD_LO or WR_LO. Fetch is always a read.
- Each LO/HI state lasts ACCESS_CYCLES cycles, counted by an internal counter. The LO state uses half = 0, which carries data bits [15:0]. The HI state uses half = 1, which carries bits [31:16].
- Read: mc_ram_addr is held for the whole state. mc_ram_dq_in is captured on the last cycle of the state into the winner's data-register half.
- Write: mc_ram_dq_oe = 1 and mc_ram_dq_out = the matching wdata half for the entire state. mc_ram_we_n = 0 on every cycle of the state except the last, which is a hold cycle with we_n = 1 and address/data stable.
- DONE: lasts 1 cycle and pulses the winner's ack. Read data is already valid in its output register in this cycle and stays unchanged until that port's next read completes. Next state is IDLE.
- Requester handshake: the enable must be dropped before the IDLE cycle that follows the ack. If the enable is still high in that cycle, it is a new request.
- Arbitration in IDLE: described under Configuration. A single requester always wins immediately.
- Writes never update mc_mem_rdata. Fetch data registers are independent of data-port registers.

## Timing
- Reset values: state IDLE, counter 0, mc_ram_addr 0, mc_ram_we_n 1, mc_ram_dq_oe 0, mc_ram_dq_out 0, both acks 0, both read data registers 0, priority pointer = data port.
- All outputs are registered. Reset mid-transaction aborts immediately to the reset values. No ack is produced for the aborted transaction, and the SRAM write is truncated.
- Latency from the IDLE cycle that samples en to ack is 2·ACCESS_CYCLES + 1 cycles. With the default, this is 5. Throughput is one word per 2·ACCESS_CYCLES + 2 cycles.
- mc_ram_we_n is never low in IDLE, DONE or read states. mc_ram_dq_oe is high only in WR_LO/WR_HI.
- Enables and address changes outside IDLE are ignored.

## Configuration
- SRAM_ARB_ROUND_ROBIN_EN defined: priority alternates. After a grant, the pointer moves to the other port. When both request, the pointer's port wins.
- Undefined: fixed priority. The data port always beats fetch when both request, and the pointer is unused.

## Test plan
- Reset, then fetch read at 0x00010: SRAM returns 0x5678 at halfword addr 0x00008 and 0x1234 at 0x00009 -> mc_if_ack 5 cycles after the sampling IDLE; mc_if_data = 0x12345678; we_n stays 1.
- Data write 0xDEADBEEF to 0x00020 -> BEEF driven to addr 0x00010 and DEAD to 0x00011. we_n low for 1 cycle per half with dq_oe high. mc_mem_ack is pulsed and mc_mem_rdata is unchanged.
- Both ports request continuously, round-robin build -> grants alternate data, fetch, data, … Fixed-priority build -> only data is granted while mem_mc_en is held.
- Enable held high past ack -> a second identical transaction starts in the next IDLE.
- Reset asserted during WR_LO -> same cycle: we_n = 1, dq_oe = 0, state IDLE; no ack.
- Address bits [1:0] = 2'b11 -> same SRAM addresses as 2'b00.
